// File: rtl/matrix_stream_tx_if.sv
// Output stream bundle of matrix_stream_tx: data, valid, sideband user field and ready.
// UW carries {K, new_a}.
interface matrix_stream_tx_if #(
  parameter int INW = 12,
  parameter int UW  = 5
);
  logic [INW-1:0] tdata;
  logic           tvalid;
  logic [UW-1:0]  tuser;
  logic           tready;

  modport master (output tdata, output tvalid, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tuser, output tready);
endinterface

// File: rtl/matrix_stream_tx.sv
// Matrix transmitter: holds A (MxMAXK) and B (MAXKxN) and streams A then B, or B only, row-major.
// Optional stall counter output is enabled by defining MATRIX_TX_STALL_STATS_EN.
module matrix_stream_tx #(
  parameter int INW  = 12,
  parameter int M    = 7,
  parameter int N    = 9,
  parameter int MAXK = 8,
  localparam int K_BITS = $clog2(MAXK + 1),
  localparam int ADDR_W = $clog2(MAXK * ((M > N) ? M : N))
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic              i_wr_sel_b,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [INW-1:0]    i_wr_data,
  input  logic              i_start,
  input  logic [K_BITS-1:0] i_k_in,
  input  logic              i_new_a,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  matrix_stream_tx_if.master out_if
`ifdef MATRIX_TX_STALL_STATS_EN
  ,
  output logic [31:0]       o_stall_cycles
`endif
);

  localparam int A_DEPTH = M * MAXK;
  localparam int B_DEPTH = MAXK * N;
  localparam int A_AW    = $clog2(A_DEPTH);
  localparam int B_AW    = $clog2(B_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SEND_A, S_SEND_B} state_t;

  state_t              r_state, w_nxt_state;
  logic [K_BITS-1:0]   r_k, w_nxt_k;
  logic [ADDR_W-1:0]   r_idx, w_nxt_idx;
  logic [INW-1:0]      r_tdata, w_nxt_tdata;
  logic                r_tvalid, w_nxt_tvalid;
  logic [K_BITS:0]     r_tuser, w_nxt_tuser;
  logic                r_done, w_nxt_done;
  logic                r_err, w_nxt_err;
  logic                w_start_ok;
  logic                w_k_ok;
  logic                w_hs;
  logic [ADDR_W-1:0]   w_idx_inc;
  logic [ADDR_W-1:0]   w_a_last;
  logic [ADDR_W-1:0]   w_b_last;

  logic [INW-1:0]      r_mem_a [A_DEPTH];
  logic [INW-1:0]      r_mem_b [B_DEPTH];

  assign w_hs      = r_tvalid && out_if.tready;
  assign w_k_ok    = (i_k_in != '0) && (int'(i_k_in) <= MAXK);
  assign w_idx_inc = r_idx + ADDR_W'(1);
  assign w_a_last  = ADDR_W'(M * int'(r_k) - 1);
  assign w_b_last  = ADDR_W'(int'(r_k) * N - 1);

  // Storage has no reset; it is only writable while idle so a transfer sees a frozen image.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && i_wr_en) begin
      if (!i_wr_sel_b && int'(i_wr_addr) < A_DEPTH)
        r_mem_a[i_wr_addr[A_AW-1:0]] <= i_wr_data;
      if (i_wr_sel_b && int'(i_wr_addr) < B_DEPTH)
        r_mem_b[i_wr_addr[B_AW-1:0]] <= i_wr_data;
    end
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_k      = r_k;
    w_nxt_idx    = r_idx;
    w_nxt_tdata  = r_tdata;
    w_nxt_tvalid = r_tvalid;
    w_nxt_tuser  = r_tuser;
    w_nxt_done   = 1'b0;
    w_nxt_err    = 1'b0;
    w_start_ok   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_k_ok) begin
            w_start_ok   = 1'b1;
            w_nxt_k      = i_k_in;
            w_nxt_idx    = '0;
            w_nxt_tvalid = 1'b1;
            w_nxt_tuser  = {i_k_in, i_new_a};
            if (i_new_a) begin
              w_nxt_state = S_SEND_A;
              w_nxt_tdata = r_mem_a[0];
            end else begin
              w_nxt_state = S_SEND_B;
              w_nxt_tdata = r_mem_b[0];
            end
          end else begin
            w_nxt_err = 1'b1;
          end
        end
      end
      // Next beat is preloaded on each handshake so the A->B crossing costs no cycle.
      S_SEND_A: begin
        if (w_hs) begin
          if (r_idx == w_a_last) begin
            w_nxt_state = S_SEND_B;
            w_nxt_idx   = '0;
            w_nxt_tdata = r_mem_b[0];
          end else begin
            w_nxt_idx   = w_idx_inc;
            w_nxt_tdata = r_mem_a[w_idx_inc[A_AW-1:0]];
          end
        end
      end
      S_SEND_B: begin
        if (w_hs) begin
          if (r_idx == w_b_last) begin
            w_nxt_state  = S_IDLE;
            w_nxt_idx    = '0;
            w_nxt_tvalid = 1'b0;
            w_nxt_done   = 1'b1;
          end else begin
            w_nxt_idx   = w_idx_inc;
            w_nxt_tdata = r_mem_b[w_idx_inc[B_AW-1:0]];
          end
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_idx    <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tuser  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_k      <= w_nxt_k;
      r_idx    <= w_nxt_idx;
      r_tdata  <= w_nxt_tdata;
      r_tvalid <= w_nxt_tvalid;
      r_tuser  <= w_nxt_tuser;
      r_done   <= w_nxt_done;
      r_err    <= w_nxt_err;
    end
  end

  assign out_if.tdata  = r_tdata;
  assign out_if.tvalid = r_tvalid;
  assign out_if.tuser  = r_tuser;
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_err         = r_err;

`ifdef MATRIX_TX_STALL_STATS_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk) begin
    if (reset)
      r_stall <= '0;
    else if (w_start_ok)
      r_stall <= '0;
    else if (r_tvalid && !out_if.tready && r_stall != '1)
      r_stall <= r_stall + 32'd1;
  end

  assign o_stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_matrix_stream_tx.sv
// Randomized bench for matrix_stream_tx against a queue-based transfer model.
// Stall counter checks are active when MATRIX_TX_STALL_STATS_EN is defined.
module tb_matrix_stream_tx;
  localparam int INW = 12, M = 7, N = 9, MAXK = 8;
  localparam int K_BITS = 4, ADDR_W = 7;
  localparam int A_DEPTH = M * MAXK, B_DEPTH = MAXK * N;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0, wr_sel_b = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [INW-1:0]    wr_data = '0;
  logic              start = 1'b0, new_a = 1'b0;
  logic [K_BITS-1:0] k_in = '0;
  logic              busy, done, err;
  logic [31:0]       stall_cycles;

  matrix_stream_tx_if #(.INW(INW), .UW(K_BITS + 1)) s_if ();

  matrix_stream_tx dut (
    .clk(clk), .reset(reset),
    .i_wr_en(wr_en), .i_wr_sel_b(wr_sel_b), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_start(start), .i_k_in(k_in), .i_new_a(new_a),
    .o_busy(busy), .o_done(done), .o_err(err),
    .out_if(s_if)
`ifdef MATRIX_TX_STALL_STATS_EN
    , .o_stall_cycles(stall_cycles)
`endif
  );

`ifndef MATRIX_TX_STALL_STATS_EN
  assign stall_cycles = '0;
`endif

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [INW-1:0] ma [A_DEPTH];
  logic [INW-1:0] mb [B_DEPTH];
  logic [INW-1:0] exp_d [$];
  logic [K_BITS:0] exp_u [$];
  int tr_mode = 0;
  int xfer_beats = 0, stall_model = 0, vcyc = 0, done_cnt = 0, err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = random, 2 = 1,0,0 repeating
  initial begin
    int ph;
    ph = 0;
    s_if.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (tr_mode)
        1: s_if.tready = ($urandom_range(0, 3) != 0);
        2: s_if.tready = (ph == 0);
        default: s_if.tready = 1'b1;
      endcase
      ph = (ph + 1) % 3;
    end
  end

  initial begin
    logic prev_stall, prev_hs;
    logic [INW-1:0] prev_data;
    logic [K_BITS:0] prev_user;
    prev_stall = 0; prev_hs = 0; prev_data = '0; prev_user = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 0; prev_hs = 0;
        continue;
      end
      if (prev_stall) begin
        check("hold_valid", 64'(s_if.tvalid), 64'd1);
        check("hold_data", 64'(s_if.tdata), 64'(prev_data));
        check("hold_user", 64'(s_if.tuser), 64'(prev_user));
      end
      if (done) begin
        done_cnt++;
        check("done_after_last", 64'(prev_hs), 64'd1);
      end
      if (err) err_cnt++;
      if (s_if.tvalid) vcyc++;
      prev_hs    = s_if.tvalid && s_if.tready;
      prev_stall = s_if.tvalid && !s_if.tready;
      if (prev_stall) stall_model++;
      if (prev_hs) begin
        xfer_beats++;
        if (exp_d.size() == 0) check("extra_beat", 64'd1, 64'd0);
        else begin
          check("beat_data", 64'(s_if.tdata), 64'(exp_d.pop_front()));
          check("beat_user", 64'(s_if.tuser), 64'(exp_u.pop_front()));
        end
      end
      prev_data = s_if.tdata;
      prev_user = s_if.tuser;
    end
  end

  task automatic wr(input bit sel, input int addr, input logic [INW-1:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_sel_b = sel; wr_addr = ADDR_W'(addr); wr_data = d;
    if (!sel && addr < A_DEPTH) ma[addr] = d;
    if (sel && addr < B_DEPTH) mb[addr] = d;
  endtask

  task automatic wr_stop();
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // b2b: caller sits at the negedge of the done cycle, so start is raised inside that cycle
  task automatic start_xfer(input int k, input bit na, input bit b2b);
    logic [K_BITS:0] u;
    u = {K_BITS'(k), na};
    if (na)
      for (int r = 0; r < M; r++)
        for (int c = 0; c < k; c++) begin
          exp_d.push_back(ma[r * k + c]); exp_u.push_back(u);
        end
    for (int r = 0; r < k; r++)
      for (int c = 0; c < N; c++) begin
        exp_d.push_back(mb[r * N + c]); exp_u.push_back(u);
      end
    xfer_beats = 0; stall_model = 0; vcyc = 0;
    if (!b2b) begin
      @(posedge clk); #1;
    end
    start = 1'b1; k_in = K_BITS'(k); new_a = na;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_valid", 64'(s_if.tvalid), 64'd1);
    check("start_busy", 64'(busy), 64'd1);
    check("start_user", 64'(s_if.tuser), 64'(u));
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    else begin
      check("end_valid", 64'(s_if.tvalid), 64'd0);
      check("end_busy", 64'(busy), 64'd0);
      check("leftover", 64'(exp_d.size()), 64'd0);
`ifdef MATRIX_TX_STALL_STATS_EN
      check("stall_cycles", 64'(stall_cycles), 64'(stall_model));
`endif
    end
  endtask

  task automatic bad_start(input int k);
    int e0;
    e0 = err_cnt;
    @(posedge clk); #1;
    start = 1'b1; k_in = K_BITS'(k); new_a = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rej_err", 64'(err), 64'd1);
    check("rej_valid", 64'(s_if.tvalid), 64'd0);
    check("rej_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("rej_err_1cyc", 64'(err), 64'd0);
    check("rej_valid2", 64'(s_if.tvalid), 64'd0);
    check("rej_err_cnt", 64'(err_cnt - e0), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, d0, k;
    bit na, rl;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_valid", 64'(s_if.tvalid), 64'd0);
    check("rst_data", 64'(s_if.tdata), 64'd0);
    check("rst_user", 64'(s_if.tuser), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_stall", 64'(stall_cycles), 64'd0);

    for (int i = 0; i < A_DEPTH; i++) wr(1'b0, i, INW'(i + 1));
    for (int i = 0; i < B_DEPTH; i++) wr(1'b1, i, INW'(100 + i));
    wr(1'b0, 60, 12'hABC);
    wr(1'b1, 100, 12'hDEF);
    wr_stop();

    // basic new-A, then reuse A
    tr_mode = 0;
    start_xfer(2, 1'b1, 1'b0);
    wait_done();
    check("basic_vcyc", 64'(vcyc), 64'd32);
    start_xfer(3, 1'b0, 1'b1);
    wait_done();
    check("reuse_beats", 64'(xfer_beats), 64'd27);

    // backpressure
    tr_mode = 2;
    start_xfer(4, 1'b1, 1'b0);
    wait_done();
    check("bp_beats", 64'(xfer_beats), 64'd64);

    // invalid K then maximum K
    tr_mode = 0;
    bad_start(0);
    bad_start(9);
    start_xfer(8, 1'b1, 1'b0);
    wait_done();
    check("kmax_beats", 64'(xfer_beats), 64'd128);

    // writes and start while busy
    tr_mode = 1;
    start_xfer(5, 1'b1, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    e0 = err_cnt;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_sel_b = i[0]; wr_addr = ADDR_W'(i * 3); wr_data = 12'hF00 | INW'(i);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    start = 1'b1; k_in = 4'd0; new_a = 1'b0;
    @(posedge clk); #1;
    k_in = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    check("busy_no_err", 64'(err_cnt - e0), 64'd0);
    check("busy_beats", 64'(xfer_beats), 64'd80);
    start_xfer(5, 1'b1, 1'b1);
    wait_done();

    // reset mid-transfer
    tr_mode = 0;
    d0 = done_cnt;
    start_xfer(3, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (xfer_beats >= 5) break;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_valid", 64'(s_if.tvalid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    exp_d.delete(); exp_u.delete();
    repeat (2) @(posedge clk);
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    start_xfer(3, 1'b1, 1'b0);
    wait_done();
    check("midrst_resend", 64'(xfer_beats), 64'd48);

    // randomized transfers
    for (int it = 0; it < 14; it++) begin
      rl = ($urandom_range(0, 1) == 1);
      if (rl) begin
        for (int j = 0; j < 12; j++)
          wr(1'($urandom_range(0, 1)), int'($urandom_range(0, 127)), INW'($urandom));
        wr_stop();
      end
      k = int'($urandom_range(1, MAXK));
      na = 1'($urandom_range(0, 1));
      tr_mode = int'($urandom_range(0, 2));
      d0 = done_cnt;
      start_xfer(k, na, !rl);
      wait_done();
      @(posedge clk); #1;
      check("rand_beats", 64'(xfer_beats), 64'(na ? (M * k + k * N) : (k * N)));
      check("rand_done_once", 64'(done_cnt - d0), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_stream_tx.md
# matrix_stream_tx

AXI-Stream matrix transmitter that feeds the matrix-multiply accelerator's input port. It holds one A matrix (M×K) and one B matrix (K×N) in local register storage, loaded through a simple write port. On `start` it streams A then B (or B only when A is reused) as row-major beats, with `TUSER` carrying K and the new-A flag. It sits between the host/loader side and the accelerator's `INPUT_*` interface, and also serves as the bench-side driver.

## Interface
- `INW`, 12, element width (signed)
- `M`, 7, rows of A
- `N`, 9, columns of B
- `MAXK`, 8, maximum inner dimension; `K_BITS = $clog2(MAXK+1)` (localparam)

Ports (reset: `reset`, synchronous, active-high; clock: `clk`):
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `wr_en`  in  1  storage write strobe
- `wr_sel_b`  in  1  0 = write A storage, 1 = write B storage
- `wr_addr`  in  `$clog2(MAXK*max(M,N))`  row-major element address
- `wr_data`  in  INW  element value
- `start`  in  1  begin a transfer
- `k_in`  in  K_BITS  inner dimension for this transfer
- `new_a`  in  1  1 = send A then B; 0 = send B only
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle pulse after the final handshake
- `err`  out  1  one-cycle pulse when `start` is rejected
- `OUTPUT_TDATA`  out  INW  stream data
- `OUTPUT_TVALID`  out  1  stream valid
- `OUTPUT_TUSER`  out  K_BITS+1  `{K, new_a}`: bits `[K_BITS:1]` = K, bit `[0]` = new_a
- `OUTPUT_TREADY`  in  1  consumer ready
- `stall_cycles`  out  32  present only with `MATRIX_TX_STALL_STATS_EN`

## Operation
- **States:** IDLE, SEND_A, SEND_B.
- **IDLE:**
  - `wr_en` writes `wr_data` into A or B storage at `wr_addr`.
  - Addresses ≥ M·MAXK (A) or ≥ MAXK·N (B) are dropped.
- **Start acceptance:** `start` in IDLE with 1 ≤ `k_in` ≤ MAXK latches K and new_a.
  - Next state is SEND_A if new_a = 1, else SEND_B.
- **Start rejection:** `start` with `k_in` = 0 or `k_in` > MAXK stays in IDLE and pulses `err` the next cycle.
- **SEND_A:** emits A[r·K+c] for r = 0..M-1, c = 0..K-1 (M·K beats). After the last handshake, moves to SEND_B.
- **SEND_B:** emits B[r·N+c] for r = 0..K-1, c = 0..N-1 (K·N beats). After the last handshake, moves to IDLE and pulses `done`.
- Storage is addressed with the latched K. Stale storage beyond K is never sent.
- `TUSER` is held at the latched `{K, new_a}` for every beat of the transfer.
- **Ignored while busy:**
  - `wr_en` is ignored (storage is frozen).
  - `start` is ignored, and `err` does not pulse.
- **Reset:** returns to IDLE and clears the beat counters. Storage contents are not reset.

## Timing
- **Reset values:** `OUTPUT_TVALID`=0, `OUTPUT_TDATA`=0, `OUTPUT_TUSER`=0, `busy`=0, `done`=0, `err`=0, `stall_cycles`=0.
- **Output registers:** all stream outputs are registered. There are no combinational paths from `OUTPUT_TREADY` to any output.
- **Start latency:** with `start` accepted at edge t, `TVALID`=1 and `busy`=1 from t+1, and the first element is on `TDATA`.
- **Handshake:** a transfer occurs on any edge where `TVALID` && `TREADY`.
  - Once `TVALID` is high, `TDATA`/`TUSER` stay stable until the handshake.
  - `TVALID` never drops mid-transfer except on reset.
- **Throughput:** 1 beat/cycle when `TREADY` is held high. There is no bubble at the A→B boundary.
  - A full new-A transfer occupies exactly M·K + K·N cycles of `TVALID`.
- **Transfer end:** at the edge of the final handshake, `TVALID`→0, `busy`→0 and `done`→1 (for 1 cycle).
  - A new `start` is accepted from the cycle `done` is high.
- **Reset mid-transfer:** `TVALID` is 0 in the cycle after the reset edge. No partial beat is re-sent.

## Configuration
- **`MATRIX_TX_STALL_STATS_EN` defined:**
  - `stall_cycles` exists and counts cycles with `TVALID`=1 && `TREADY`=0.
  - It is cleared when a `start` is accepted, holds its value after `done`, and saturates at 2^32-1.
- **Undefined:** the port and its counter logic are absent. Stream behaviour is identical in both cases.

## Test plan
- **Basic new-A transfer:** load A[i]=i+1, B[i]=100+i; start k_in=2, new_a=1, `TREADY`=1.
  - Expect 14 A beats (1..14), then 18 B beats (100..117).
  - `TUSER`=5 on every beat; `done` one cycle after beat 32.
- **Reuse A:** start k_in=3, new_a=0.
  - Expect exactly 27 beats B[0..26] with `TUSER`=6.
  - No A beats; `done` after the 27th handshake.
- **Backpressure:** `TREADY` toggles 1,0,0,1,… during the transfer.
  - `TDATA`/`TUSER` are stable across every stall, with no beat lost or duplicated.
  - With the macro defined, `stall_cycles` equals the count of stalled valid cycles.
- **Invalid K:** start with k_in=0, then with k_in=9 (MAXK=8).
  - Each gives an `err` pulse and `TVALID` stays 0.
  - A following start with k_in=8 sends 56+72 beats.
- **Busy protection:** `wr_en` and `start` asserted mid-transfer.
  - Storage is unchanged (verified on a subsequent transfer) and the transfer order is unaffected.
- **Reset mid-transfer:** reset after beat 5.
  - Next cycle: `TVALID`=0, `busy`=0.
  - A new start resends from A[0] with the original storage intact.
